hazard_unit: RTL and testbench

Parametrised stall-and-forward controller for the five-stage pipeline with mult/div unit and exception flush. It replaces pure address-compare forwarding with Tuse/Tnew-based hazard resolution. It keeps its own shadow pipeline of destination, source and Tnew fields for the E, M and W stages. It also drives the stall signal for D and the mult/div busy interlock.

---
 rtl/hazard_unit.sv | 130 +++++++++++++
 tb/tb_hazard_unit.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// Tuse/Tnew stall-and-forward controller with a shadow E/M/W pipeline and a
// mult/div busy interlock. All outputs are combinational from shadow state and D inputs.
module hazard_unit #(
    parameter int AW       = 5,
    parameter int TW       = 2,
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int CW       = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] rs_D,
    input  logic [AW-1:0] rt_D,
    input  logic          use_rs_D,
    input  logic          use_rt_D,
    input  logic [TW-1:0] tuse_rs_D,
    input  logic [TW-1:0] tuse_rt_D,
    input  logic [AW-1:0] wa_D,
    input  logic [TW-1:0] tnew_D,
    input  logic          md_start_D,
    input  logic          md_div_D,
    input  logic          md_use_D,
    input  logic          flush,
    output logic          stall,
    output logic [1:0]    fwd_rs_D,
    output logic [1:0]    fwd_rt_D,
    output logic [1:0]    fwd_rs_E,
    output logic [1:0]    fwd_rt_E,
    output logic          fwd_rt_M,
    output logic          md_busy
);

    typedef struct packed {
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic [AW-1:0] wa;
        logic [TW-1:0] tnew;
    } shadow_t;

    shadow_t       e_q, m_q, w_q;
    logic          e_md_q;
    logic [CW-1:0] cnt_q;
    logic          stall_rs, stall_rt, stall_md;

    function automatic logic hit(input logic [AW-1:0] src, input logic [AW-1:0] wa);
        return (src != '0) && (src == wa);
    endfunction

    function automatic shadow_t age(input shadow_t s);
        shadow_t r;
        r = s;
        if (s.tnew != '0)
            r.tnew = s.tnew - TW'(1);
        return r;
    endfunction

    function automatic logic src_stall(input logic use_src, input logic [AW-1:0] src,
                                       input logic [TW-1:0] tuse,
                                       input shadow_t e, input shadow_t m);
        return use_src && ((hit(src, e.wa) && (e.tnew > tuse)) ||
                           (hit(src, m.wa) && (m.tnew > tuse)));
    endfunction

    // Nearest match decides; a not-yet-ready newer writer blocks older ones.
    function automatic logic [1:0] fwd_sel_d(input logic [AW-1:0] src, input shadow_t e,
                                             input shadow_t m, input shadow_t w);
        if (hit(src, e.wa))
            return (e.tnew == '0) ? 2'd1 : 2'd0;
        if (hit(src, m.wa))
            return (m.tnew == '0) ? 2'd2 : 2'd0;
        if (hit(src, w.wa))
            return (w.tnew == '0) ? 2'd3 : 2'd0;
        return 2'd0;
    endfunction

    function automatic logic [1:0] fwd_sel_e(input logic [AW-1:0] src, input shadow_t m,
                                             input shadow_t w);
        if (hit(src, m.wa))
            return (m.tnew == '0) ? 2'd2 : 2'd0;
        if (hit(src, w.wa))
            return (w.tnew == '0) ? 2'd3 : 2'd0;
        return 2'd0;
    endfunction

    assign stall_rs = src_stall(use_rs_D, rs_D, tuse_rs_D, e_q, m_q);
    assign stall_rt = src_stall(use_rt_D, rt_D, tuse_rt_D, e_q, m_q);
    assign md_busy  = (cnt_q != '0);
    assign stall_md = md_use_D && (md_busy || e_md_q);
    assign stall    = (stall_rs || stall_rt || stall_md) && !flush;

    assign fwd_rs_D = fwd_sel_d(rs_D, e_q, m_q, w_q);
    assign fwd_rt_D = fwd_sel_d(rt_D, e_q, m_q, w_q);
    assign fwd_rs_E = fwd_sel_e(e_q.rs, m_q, w_q);
    assign fwd_rt_E = fwd_sel_e(e_q.rt, m_q, w_q);
    assign fwd_rt_M = hit(m_q.rt, w_q.wa);

    // W keeps aging too, so any legal producer (tnew <= 2) reads as ready in W.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_q    <= '0;
            m_q    <= '0;
            w_q    <= '0;
            e_md_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            if (flush) begin
                e_q    <= '0;
                m_q    <= '0;
                w_q    <= '0;
                e_md_q <= 1'b0;
            end else begin
                w_q <= age(m_q);
                m_q <= age(e_q);
                if (stall) begin
                    e_q    <= '0;
                    e_md_q <= 1'b0;
                end else begin
                    e_q    <= {rs_D, rt_D, wa_D, tnew_D};
                    e_md_q <= md_start_D;
                end
            end
            // Flush never touches the counter: an issued mult/div runs to completion.
            if (md_start_D && !stall && !flush)
                cnt_q <= md_div_D ? CW'(DIV_CYC) : CW'(MULT_CYC);
            else if (cnt_q != '0)
                cnt_q <= cnt_q - CW'(1);
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: instruction-history reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_hazard_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic       clk, reset;
    logic [4:0] rs_D, rt_D, wa_D;
    logic       use_rs_D, use_rt_D;
    logic [1:0] tuse_rs_D, tuse_rt_D, tnew_D;
    logic       md_start_D, md_div_D, md_use_D, flush;
    logic       stall, fwd_rt_M, md_busy;
    logic [1:0] fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    hazard_unit dut (
        .clk(clk), .reset(reset),
        .rs_D(rs_D), .rt_D(rt_D), .use_rs_D(use_rs_D), .use_rt_D(use_rt_D),
        .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D), .wa_D(wa_D), .tnew_D(tnew_D),
        .md_start_D(md_start_D), .md_div_D(md_div_D), .md_use_D(md_use_D), .flush(flush),
        .stall(stall), .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D),
        .fwd_rs_E(fwd_rs_E), .fwd_rt_E(fwd_rt_E), .fwd_rt_M(fwd_rt_M), .md_busy(md_busy)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // hist[k] is the instruction that entered E k cycles ago (0 = E, 1 = M, 2 = W).
    typedef struct {
        bit v;
        int rs;
        int rt;
        int wa;
        int tnew;
        bit md;
    } ent_t;

    ent_t hist[3];
    bit   md_active;
    int   md_issue, md_len;

    function automatic bit m_hit(int s, int k);
        return hist[k].v && s != 0 && s == hist[k].wa;
    endfunction

    function automatic int m_rem(int k);
        int r;
        r = hist[k].tnew - k;
        return (r < 0) ? 0 : r;
    endfunction

    function automatic bit m_dstall(bit u, int s, int tu);
        return u && ((m_hit(s, 0) && m_rem(0) > tu) || (m_hit(s, 1) && m_rem(1) > tu));
    endfunction

    function automatic int m_fwd(int s, int k0);
        for (int k = k0; k < 3; k++)
            if (m_hit(s, k))
                return (m_rem(k) == 0) ? k + 1 : 0;
        return 0;
    endfunction

    function automatic bit m_busy();
        return md_active && cyc > md_issue && cyc <= md_issue + md_len;
    endfunction

    function automatic bit m_stall();
        bit s;
        s = m_dstall(use_rs_D, int'(rs_D), int'(tuse_rs_D)) ||
            m_dstall(use_rt_D, int'(rt_D), int'(tuse_rt_D)) ||
            (md_use_D && (m_busy() || hist[0].md));
        return s && !flush;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 3; k++) hist[k] = '{0, 0, 0, 0, 0, 0};
    endtask

    task automatic model_update();
        bit st;
        st = m_stall();
        if (reset) begin
            model_clear();
            md_active = 0;
        end else begin
            if (md_start_D && !st && !flush) begin
                md_active = 1;
                md_issue  = cyc;
                md_len    = md_div_D ? DIV_N : MULT_N;
            end
            if (flush) begin
                model_clear();
            end else begin
                hist[2] = hist[1];
                hist[1] = hist[0];
                if (st) hist[0] = '{0, 0, 0, 0, 0, 0};
                else    hist[0] = '{1, int'(rs_D), int'(rt_D), int'(wa_D), int'(tnew_D), md_start_D};
            end
        end
        cyc++;
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(string name, int got, int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d cyc=%0d", name, got, exp, cyc);
        end
    endtask

    task automatic check_model();
        chk("m_stall",    int'(stall),    int'(m_stall()));
        chk("m_fwd_rs_D", int'(fwd_rs_D), m_fwd(int'(rs_D), 0));
        chk("m_fwd_rt_D", int'(fwd_rt_D), m_fwd(int'(rt_D), 0));
        chk("m_fwd_rs_E", int'(fwd_rs_E), m_fwd(hist[0].rs, 1));
        chk("m_fwd_rt_E", int'(fwd_rt_E), m_fwd(hist[0].rt, 1));
        chk("m_fwd_rt_M", int'(fwd_rt_M), int'(hist[1].rt != 0 && hist[1].rt == hist[2].wa));
        chk("m_md_busy",  int'(md_busy),  int'(m_busy()));
    endtask

    // ---------------- driver tasks ----------------
    task automatic settle();
        #1;
    endtask

    task automatic step();
        #1;
        check_model();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        rs_D = 0; rt_D = 0; use_rs_D = 0; use_rt_D = 0; tuse_rs_D = 0; tuse_rt_D = 0;
        wa_D = 0; tnew_D = 0; md_start_D = 0; md_div_D = 0; md_use_D = 0; flush = 0;
    endtask

    task automatic instr(int rs, int urs, int tus, int rt, int urt, int tut, int wa, int tn);
        idle();
        rs_D = 5'(rs); use_rs_D = urs[0]; tuse_rs_D = 2'(tus);
        rt_D = 5'(rt); use_rt_D = urt[0]; tuse_rt_D = 2'(tut);
        wa_D = 5'(wa); tnew_D = 2'(tn);
    endtask

    task automatic idle_steps(int n);
        idle();
        for (int i = 0; i < n; i++) step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_clear();
        md_active = 0; md_issue = 0; md_len = 0;
        idle();
        reset = 1;
        @(posedge clk);
        model_update();
        #1;
        step();
        reset = 0;
        settle();
        chk("rst_stall", int'(stall), 0);
        chk("rst_fwd_rs_D", int'(fwd_rs_D), 0);
        chk("rst_fwd_rs_E", int'(fwd_rs_E), 0);
        chk("rst_md_busy", int'(md_busy), 0);
        step();

        // addu $3 ; subu using $3 at tuse 1
        instr(0, 0, 0, 0, 0, 0, 3, 1); step();
        instr(3, 1, 1, 0, 0, 0, 0, 0); settle();
        chk("alu_nostall", int'(stall), 0);
        step();
        idle(); settle();
        chk("alu_fwd_rs_E", int'(fwd_rs_E), 2);
        step();
        idle_steps(3);

        // lw $5 ; beq $5 (tuse 0)
        instr(0, 0, 0, 0, 0, 0, 5, 2); step();
        instr(5, 1, 0, 0, 0, 0, 0, 0); settle();
        chk("lw_beq_stall1", int'(stall), 1);
        step();
        chk("lw_beq_stall2", int'(stall), 1);
        step();
        chk("lw_beq_go", int'(stall), 0);
        chk("lw_beq_fwd", int'(fwd_rs_D), 3);
        step();
        idle_steps(3);

        // jal ; jr $31
        instr(0, 0, 0, 0, 0, 0, 31, 0); step();
        instr(31, 1, 0, 0, 0, 0, 0, 0); settle();
        chk("jal_jr_stall", int'(stall), 0);
        chk("jal_jr_fwd", int'(fwd_rs_D), 1);
        step();
        idle_steps(3);

        // back-to-back writers of $4: the newest one in E wins
        instr(0, 0, 0, 0, 0, 0, 4, 1); step();
        instr(0, 0, 0, 0, 0, 0, 4, 0); step();
        instr(4, 1, 1, 0, 0, 0, 0, 0); settle();
        chk("b2b_stall", int'(stall), 0);
        chk("b2b_fwd", int'(fwd_rs_D), 1);
        step();
        idle_steps(3);

        // writer of $7 ; store of $7 -> W-to-M store data forward
        instr(0, 0, 0, 0, 0, 0, 7, 1); step();
        instr(0, 0, 0, 7, 1, 2, 0, 0); step();
        idle(); step();
        settle();
        chk("store_fwd_M", int'(fwd_rt_M), 1);
        step();
        idle_steps(3);

        // load-use pending during flush
        instr(0, 0, 0, 0, 0, 0, 6, 2); step();
        instr(6, 1, 1, 0, 0, 0, 0, 0); flush = 1; settle();
        chk("flush_stall", int'(stall), 0);
        step();
        instr(6, 1, 0, 6, 1, 0, 0, 0); settle();
        chk("flush_stall_after", int'(stall), 0);
        chk("flush_fwd_rs_D", int'(fwd_rs_D), 0);
        chk("flush_fwd_rt_D", int'(fwd_rt_D), 0);
        chk("flush_fwd_rs_E", int'(fwd_rs_E), 0);
        chk("flush_fwd_rt_M", int'(fwd_rt_M), 0);
        step();
        idle_steps(3);

        // writer to $0 ; reader of $0
        instr(0, 0, 0, 0, 0, 0, 0, 2); step();
        instr(0, 1, 0, 0, 1, 0, 0, 0); settle();
        chk("zero_stall", int'(stall), 0);
        chk("zero_fwd_rs_D", int'(fwd_rs_D), 0);
        chk("zero_fwd_rt_D", int'(fwd_rt_D), 0);
        step();
        idle(); settle();
        chk("zero_fwd_rs_E", int'(fwd_rs_E), 0);
        step();
        idle_steps(3);

        // div then mflo
        idle(); md_start_D = 1; md_div_D = 1; md_use_D = 1; settle();
        chk("div_issue", int'(stall), 0);
        step();
        idle(); md_use_D = 1;
        for (int k = 1; k <= DIV_N; k++) begin
            settle();
            chk("div_busy", int'(md_busy), 1);
            chk("mflo_wait", int'(stall), 1);
            step();
        end
        settle();
        chk("div_done", int'(md_busy), 0);
        chk("mflo_issue", int'(stall), 0);
        step();
        idle_steps(3);

        // reset in the middle of a div
        idle(); md_start_D = 1; md_div_D = 1; md_use_D = 1; step();
        idle_steps(3);
        reset = 1; settle();
        chk("rstdiv_busy_before", int'(md_busy), 1);
        step();
        reset = 0; settle();
        chk("rstdiv_busy_after", int'(md_busy), 0);
        step();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rs_D       = 5'($urandom_range(0, 7) < 6 ? $urandom_range(0, 3) : $urandom_range(0, 31));
            rt_D       = 5'($urandom_range(0, 3));
            wa_D       = 5'($urandom_range(0, 3));
            use_rs_D   = 1'($urandom_range(0, 1));
            use_rt_D   = 1'($urandom_range(0, 1));
            tuse_rs_D  = 2'($urandom_range(0, 2));
            tuse_rt_D  = 2'($urandom_range(0, 2));
            tnew_D     = 2'($urandom_range(0, 2));
            md_start_D = ($urandom_range(0, 15) == 0);
            md_div_D   = 1'($urandom_range(0, 1));
            md_use_D   = md_start_D || ($urandom_range(0, 7) == 0);
            flush      = ($urandom_range(0, 29) == 0);
            reset      = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 0;
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
